// File: rtl/mux_2_4_unit.sv
// -----------------------------------------------------------------------------
// mux_2_4_unit
//   Leaf selection primitive for the wider datapath muxes: one 2:1 and one 4:1
//   mux with zero-latency combinational outputs, plus a 1-cycle registered copy
//   of each for pipelined select paths. An 8:1 is built from two of these:
//   two 4:1 slices feed one 2:1 selected by the third select bit.
//
// Parameters
//   WIDTH    data width of every data input and output
//
// Ports
//   clk      in   1      rising-edge clock (registered outputs only)
//   reset_n  in   1      synchronous active-low reset of out2_q/out4_q
//   en       in   1      load enable for out2_q/out4_q
//   i0, i1   in   WIDTH  2:1 data inputs (sel=0 / sel=1)
//   sel      in   1      2:1 select
//   i00..i11 in   WIDTH  4:1 data inputs, named i<sel1><sel0>
//   sel0     in   1      4:1 select LSB
//   sel1     in   1      4:1 select MSB
//   out2     out  WIDTH  combinational 2:1 result
//   out4     out  WIDTH  combinational 4:1 result
//   out2_q   out  WIDTH  registered out2
//   out4_q   out  WIDTH  registered out4
// -----------------------------------------------------------------------------
module mux_2_4_unit #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             sel,
  input  logic [WIDTH-1:0] i00,
  input  logic [WIDTH-1:0] i01,
  input  logic [WIDTH-1:0] i10,
  input  logic [WIDTH-1:0] i11,
  input  logic             sel0,
  input  logic             sel1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out2_q,
  output logic [WIDTH-1:0] out4_q
);

  // First-level 4:1 intermediates: a picks from the sel1=0 pair, b from the
  // sel1=1 pair.
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

  // Registered copies and their next-state values.
  logic [WIDTH-1:0] r2_q;
  logic [WIDTH-1:0] r2_d;
  logic [WIDTH-1:0] r4_q;
  logic [WIDTH-1:0] r4_d;

  // The muxes are written as case statements with an all-X default rather
  // than the ?: operator. A ?: with an unknown select merges the two inputs
  // and would return a known value wherever they agree; an unknown select
  // must instead give an unknown output so a bad select is never hidden.
  // In synthesis the default is a don't-care.

  always_comb begin
    out2 = 'x;
    case (sel)
      1'b0:    out2 = i0;
      1'b1:    out2 = i1;
      default: out2 = 'x;
    endcase
  end

  always_comb begin
    a = 'x;
    case (sel0)
      1'b0:    a = i00;
      1'b1:    a = i01;
      default: a = 'x;
    endcase
  end

  always_comb begin
    b = 'x;
    case (sel0)
      1'b0:    b = i10;
      1'b1:    b = i11;
      default: b = 'x;
    endcase
  end

  always_comb begin
    out4 = 'x;
    case (sel1)
      1'b0:    out4 = a;
      1'b1:    out4 = b;
      default: out4 = 'x;
    endcase
  end

  // Load on enable, otherwise hold.
  assign r2_d = en ? out2 : r2_q;
  assign r4_d = en ? out4 : r4_q;

  // Reset is synchronous and takes priority over the enable.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r2_q <= '0;
      r4_q <= '0;
    end else begin
      r2_q <= r2_d;
      r4_q <= r4_d;
    end
  end

  assign out2_q = r2_q;
  assign out4_q = r4_q;

endmodule

// File: tb/tb_mux_2_4_unit.sv
// -----------------------------------------------------------------------------
// tb_mux_2_4_unit
//   Directed bench for mux_2_4_unit. Instances:
//     u1       WIDTH=1  : 4:1 and 2:1 exhaustive sweeps, reset and enable
//     u8       WIDTH=8  : byte-wide selection and registered latency
//     ua, ub   WIDTH=1  : 8:1 built from two 4:1 slices; ub's 2:1 merges them
// -----------------------------------------------------------------------------
module tb_mux_2_4_unit;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- u1 signals
  logic       u1_reset_n, u1_en, u1_sel, u1_sel0, u1_sel1;
  logic [0:0] u1_i0, u1_i1, u1_i00, u1_i01, u1_i10, u1_i11;
  logic [0:0] u1_out2, u1_out4, u1_out2_q, u1_out4_q;

  mux_2_4_unit #(.WIDTH(1)) u1 (
    .clk(clk), .reset_n(u1_reset_n), .en(u1_en),
    .i0(u1_i0), .i1(u1_i1), .sel(u1_sel),
    .i00(u1_i00), .i01(u1_i01), .i10(u1_i10), .i11(u1_i11),
    .sel0(u1_sel0), .sel1(u1_sel1),
    .out2(u1_out2), .out4(u1_out4), .out2_q(u1_out2_q), .out4_q(u1_out4_q)
  );

  // ---------------------------------------------------------------- u8 signals
  logic       u8_reset_n, u8_en, u8_sel, u8_sel0, u8_sel1;
  logic [7:0] u8_i0, u8_i1, u8_i00, u8_i01, u8_i10, u8_i11;
  logic [7:0] u8_out2, u8_out4, u8_out2_q, u8_out4_q;

  mux_2_4_unit #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(u8_reset_n), .en(u8_en),
    .i0(u8_i0), .i1(u8_i1), .sel(u8_sel),
    .i00(u8_i00), .i01(u8_i01), .i10(u8_i10), .i11(u8_i11),
    .sel0(u8_sel0), .sel1(u8_sel1),
    .out2(u8_out2), .out4(u8_out4), .out2_q(u8_out2_q), .out4_q(u8_out4_q)
  );

  // ---------------------------------------------------------------- 8:1 build
  logic [7:0] m8_d;
  logic [2:0] m8_s;
  logic [0:0] ua_out2, ua_out4, ua_out2_q, ua_out4_q;
  logic [0:0] ub_out2, ub_out4, ub_out2_q, ub_out4_q;

  mux_2_4_unit #(.WIDTH(1)) ua (
    .clk(clk), .reset_n(1'b0), .en(1'b0),
    .i0(1'b0), .i1(1'b0), .sel(1'b0),
    .i00(m8_d[0]), .i01(m8_d[1]), .i10(m8_d[2]), .i11(m8_d[3]),
    .sel0(m8_s[0]), .sel1(m8_s[1]),
    .out2(ua_out2), .out4(ua_out4), .out2_q(ua_out2_q), .out4_q(ua_out4_q)
  );

  // ub's 4:1 covers inputs 4..7; its 2:1 picks between the two slices on sel2.
  mux_2_4_unit #(.WIDTH(1)) ub (
    .clk(clk), .reset_n(1'b0), .en(1'b0),
    .i0(ua_out4), .i1(ub_out4), .sel(m8_s[2]),
    .i00(m8_d[4]), .i01(m8_d[5]), .i10(m8_d[6]), .i11(m8_d[7]),
    .sel0(m8_s[0]), .sel1(m8_s[1]),
    .out2(ub_out2), .out4(ub_out4), .out2_q(ub_out2_q), .out4_q(ub_out4_q)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // Advance to just after the next rising edge; inputs are driven and outputs
  // sampled here, well away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic u8_set_sel(input logic [1:0] s);
    u8_sel1 = s[1];
    u8_sel0 = s[0];
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [3:0] v4;
  logic [2:0] v2;
  logic [7:0] exp8;
  logic [7:0] tbl4 [4];
  logic [7:0] prev;

  initial begin
    u1_reset_n = 1'b0; u1_en = 1'b0; u1_sel = 1'b0; u1_sel0 = 1'b0; u1_sel1 = 1'b0;
    u1_i0 = '0; u1_i1 = '0; u1_i00 = '0; u1_i01 = '0; u1_i10 = '0; u1_i11 = '0;
    u8_reset_n = 1'b0; u8_en = 1'b1; u8_sel = 1'b0; u8_sel0 = 1'b0; u8_sel1 = 1'b0;
    u8_i0 = 8'h5A; u8_i1 = 8'hC3;
    u8_i00 = 8'hA5; u8_i01 = 8'h3C; u8_i10 = 8'hFF; u8_i11 = 8'h00;
    m8_d = '0; m8_s = '0;

    // Reset state: one edge with reset_n low clears both registers, even with
    // en=1 and non-zero mux results.
    step();
    check("rst_u8_out2_q", 32'(u8_out2_q), 32'h0);
    check("rst_u8_out4_q", 32'(u8_out4_q), 32'h0);
    // Combinational paths ignore reset.
    check("rst_u8_out2_comb", 32'(u8_out2), 32'h5A);
    check("rst_u8_out4_comb", 32'(u8_out4), 32'hA5);

    // 4:1 exhaustive on WIDTH=1, with en toggled as an extra bit to show the
    // combinational path does not depend on it. Expected value indexes the
    // data nibble {i11,i10,i01,i00} by {sel1,sel0}.
    for (int v = 0; v < 128; v++) begin
      {u1_en, u1_sel1, u1_sel0, u1_i00, u1_i01, u1_i10, u1_i11} = 7'(v);
      #1;
      v4 = {u1_i11, u1_i10, u1_i01, u1_i00};
      check("sweep4", 32'(u1_out4), 32'(v4[{u1_sel1, u1_sel0}]));
    end
    // Hand example: sel=01, only i01 high -> 1.
    {u1_sel1, u1_sel0, u1_i00, u1_i01, u1_i10, u1_i11} = 6'b01_0100;
    #1;
    check("ex4_sel01", 32'(u1_out4), 32'h1);

    // 2:1 exhaustive: expected indexes {i1,i0} by sel.
    for (int v = 0; v < 8; v++) begin
      {u1_sel, u1_i0, u1_i1} = 3'(v);
      #1;
      v2 = {1'b0, u1_i1, u1_i0};
      check("sweep2", 32'(u1_out2), 32'(v2[u1_sel]));
    end
    {u1_sel, u1_i0, u1_i1} = 3'b101;
    #1;
    check("ex2_sel1", 32'(u1_out2), 32'h1);

    // 8:1 from two instances: result = data bit at index {sel2,sel1,sel0}.
    for (int v = 0; v < 2048; v++) begin
      {m8_s, m8_d} = 11'(v);
      #1;
      check("sweep8", 32'(ub_out2), 32'(m8_d[m8_s]));
    end

    // Reset then release on u1: sel=00, i00=1, en=1.
    u1_en = 1'b1; u1_reset_n = 1'b0;
    {u1_sel1, u1_sel0} = 2'b00;
    {u1_i00, u1_i01, u1_i10, u1_i11} = 4'b1000;
    u1_sel = 1'b0; u1_i0 = 1'b0; u1_i1 = 1'b1;
    step();
    check("rst_hold_out4_q", 32'(u1_out4_q), 32'h0);
    check("rst_comb_out4", 32'(u1_out4), 32'h1);
    u1_reset_n = 1'b1;
    step();
    check("rst_release_out4_q", 32'(u1_out4_q), 32'h1);
    check("rst_release_out2_q", 32'(u1_out2_q), 32'h0);

    // Enable: with en=0 a change on i0 reaches out2 at once but not out2_q.
    u1_en = 1'b0; u1_i0 = 1'b1;
    #1;
    check("en0_out2_comb", 32'(u1_out2), 32'h1);
    step();
    check("en0_out2_q_hold", 32'(u1_out2_q), 32'h0);
    step();
    check("en0_out2_q_hold2", 32'(u1_out2_q), 32'h0);
    u1_en = 1'b1;
    step();
    check("en1_out2_q_load", 32'(u1_out2_q), 32'h1);

    // Reset wins over en while registers hold non-zero.
    u1_reset_n = 1'b0;
    step();
    check("rst_prio_out2_q", 32'(u1_out2_q), 32'h0);
    check("rst_prio_out4_q", 32'(u1_out4_q), 32'h0);
    u1_reset_n = 1'b1;

    // WIDTH=8: step sel 00..11; out4_q follows exactly one edge later.
    tbl4[0] = 8'hA5; tbl4[1] = 8'h3C; tbl4[2] = 8'hFF; tbl4[3] = 8'h00;
    u8_reset_n = 1'b1; u8_en = 1'b1;
    u8_set_sel(2'b00);
    step();
    prev = 8'hA5;
    for (int s = 0; s < 4; s++) begin
      u8_set_sel(2'(s));
      #1;
      exp8 = tbl4[s];
      check("w8_out4", 32'(u8_out4), 32'(exp8));
      check("w8_out4_q_before", 32'(u8_out4_q), 32'(prev));
      step();
      check("w8_out4_q_after", 32'(u8_out4_q), 32'(exp8));
      prev = exp8;
    end

    // WIDTH=8 2:1 and its registered copy.
    u8_sel = 1'b1;
    #1;
    check("w8_out2_sel1", 32'(u8_out2), 32'hC3);
    check("w8_out2_q_before", 32'(u8_out2_q), 32'h5A);
    step();
    check("w8_out2_q_after", 32'(u8_out2_q), 32'hC3);

    // en=0 holds a byte while data changes underneath.
    u8_en = 1'b0; u8_i1 = 8'h99;
    #1;
    check("w8_out2_comb_new", 32'(u8_out2), 32'h99);
    step();
    check("w8_out2_q_hold", 32'(u8_out2_q), 32'hC3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
